tx_dll_beat_packer: RTL
=======================

// Module: tx_dll_beat_packer
// PURPOSE
//  Upstream feeder of the PHY TX framing path. Accepts TLP/DLLP traffic from the data link layer one DW per
//  cycle (valid/ready), packs it into 256-bit beats and drives the TX write interface (WR_EN, SOP, End_Valid,
//  Type, Length, Last_Byte, Data). Honours the framing buffer's Full throttle with one holding beat.
// PARAMETERS
//  DATA_WIDTH       256  beat width in bits; DW slots per beat = DATA_WIDTH/32 (8)
//  PACKET_LENGTH    11   width of length field, in DW
//  SYMBOL_PTR_WIDTH 5    width of Last_Byte (byte index within beat)
// PORTS
//  CLK            in   1    clock
//  RST            in   1    asynchronous reset, active-high
//  i_EN           in   1    block enable; 0 = freeze (no accept, no write), state kept
//  i_Soft_RST     in   1    synchronous clear, same effect as RST
//  i_Pkt_Valid    in   1    DW valid from DLL
//  i_Pkt_SOP      in   1    first DW of packet
//  i_Pkt_EOP      in   1    last DW of packet
//  i_Pkt_Type     in   1    packet type, sampled with SOP (0 TLP, 1 DLLP)
//  i_Pkt_Length   in   11   packet length in DW, sampled with SOP
//  i_Pkt_Data     in   32   DW payload
//  o_Pkt_Ready    out  1    DW accepted when Valid & Ready
//  i_Full         in   1    framing buffer full
//  o_WR_EN        out  1    beat write strobe
//  o_SOP          out  1    beat holds first DW of packet
//  o_End_Valid    out  1    beat holds last DW of packet
//  o_Type         out  1    packet type
//  o_Length       out  11   packet length (DW), valid with o_SOP
//  o_Last_Byte    out  5    index of last valid byte in beat, valid with o_End_Valid
//  o_Data         out  [0:255] beat; DW k at bits [32k:32k+31], unused slots zero
//  o_Proto_Err    out  1    sticky: SOP mid-packet, DW outside packet, or length 0
//  o_Len_Err      out  1    sticky: DW count at EOP != sampled length
// BEHAVIOUR
//  - Reset (RST or i_Soft_RST): all outputs 0, fill/out registers empty, FSM IDLE, error flags cleared.
//  - FSM: IDLE (no packet open) -> IN_PKT on accepted SOP DW; IN_PKT -> IDLE on accepted EOP DW.
//    SOP&EOP on same DW = single-DW packet, stays IDLE.
//  - Fill stage: up to 8 DW slots + slot ptr (3b). Accepted DW written to slot ptr; ptr++.
//    Beat complete when slot 7 written or EOP accepted; complete beat carries SOP flag (first beat of pkt),
//    End flag (EOP in beat), Type, Length, Last_Byte = 4*(DW in beat)-1.
//  - Out stage: one register + out_v. Complete fill moves to out on next edge if !out_v or out written this
//    cycle; fill ptr resets to 0; packet attributes retained for following beats.
//  - o_WR_EN = out_v & !i_Full & i_EN (combinational on i_Full); out_v clears on write unless refilled.
//  - o_Pkt_Ready = i_EN & !(fill complete & out cannot accept). A beat never mixes two packets.
//  - Latency: DW closing a beat accepted at edge t -> o_WR_EN high in cycle t+1 (if i_Full low).
//  - Full back-to-back: 1 DW/cycle sustained with i_Full low; beat written every 8 cycles.
//  - i_Full high: out holds, fill completes, Ready drops; no DW lost, beats emitted in order after release.
//  - Error handling: SOP in IN_PKT -> DW dropped, o_Proto_Err set, packet continues. Non-SOP DW in IDLE ->
//    dropped, o_Proto_Err. SOP with length 0 -> o_Proto_Err, packet still forwarded. At EOP, DW count
//    (11b, wraps) != Length -> o_Len_Err; packet forwarded as received.
//  - i_EN low: Ready=0, WR_EN=0, all registers hold; resumes identically when raised.
//  - Data in outputs stable while out_v & i_Full (no change until written).
// TESTING
//  - 1-DW DLLP (SOP&EOP, Type=1, Len=1, data 32'hA5A5_0001) -> next cycle WR_EN=1, SOP=1, End_Valid=1,
//    Last_Byte=3, Data[0:31]=A5A50001, rest 0.
//  - 11-DW TLP, i_Full=0, Valid every cycle -> beat1 SOP=1 End=0 8 DW; beat2 End=1 Last_Byte=11, Length=11.
//  - Same TLP with i_Full high cycles 3..20 -> Ready low after fill completes, beats emitted in order after
//    release, data identical, no duplicate WR_EN.
//  - Two 8-DW packets back-to-back -> WR_EN at 8-cycle spacing, each beat SOP=End=1, Last_Byte=31.
//  - SOP mid-packet and EOP after Len=4 but 3 DW -> o_Proto_Err=1, o_Len_Err=1, stay set until reset.
//  - RST asserted mid-packet with out_v=1 -> all outputs 0 immediately, next SOP packet framed correctly.

Source files
------------

// File: rtl/tx_dll_beat_packer.sv
`timescale 1ns/1ps
// Packs DLL DWs (one per cycle) into 256-bit beats for the PHY TX framing write port.
// Latency: the DW closing a beat is accepted at edge t and written in the cycle right after edge t.
// Backpressure: i_Full holds the out beat, the fill stage may complete one more beat, then Ready drops.
module tx_dll_beat_packer #(
  parameter int DATA_WIDTH       = 256,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_EN,
  input  logic                        i_Soft_RST,
  input  logic                        i_Pkt_Valid,
  input  logic                        i_Pkt_SOP,
  input  logic                        i_Pkt_EOP,
  input  logic                        i_Pkt_Type,
  input  logic [PACKET_LENGTH-1:0]    i_Pkt_Length,
  input  logic [31:0]                 i_Pkt_Data,
  output logic                        o_Pkt_Ready,
  input  logic                        i_Full,
  output logic                        o_WR_EN,
  output logic                        o_SOP,
  output logic                        o_End_Valid,
  output logic                        o_Type,
  output logic [PACKET_LENGTH-1:0]    o_Length,
  output logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte,
  output logic [0:DATA_WIDTH-1]       o_Data,
  output logic                        o_Proto_Err,
  output logic                        o_Len_Err
);
  localparam int SLOTS = DATA_WIDTH / 32;
  localparam int PTR_W = $clog2(SLOTS);

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;
  state_t state_q, state_d;

  logic [0:DATA_WIDTH-1]       fill_data_q, fill_data_d, out_data_q, out_data_d, b_data, n_data;
  logic [PTR_W-1:0]            fill_ptr_q, fill_ptr_d, b_ptr;
  logic                        fill_sop_q, fill_sop_d, fill_end_q, fill_end_d, fill_cmpl_q, fill_cmpl_d;
  logic [SYMBOL_PTR_WIDTH-1:0] fill_lb_q, fill_lb_d, out_lb_q, out_lb_d, n_lb;
  logic                        out_v_q, out_v_d, out_sop_q, out_sop_d, out_end_q, out_end_d;
  logic                        out_type_q, out_type_d, pkt_type_q, pkt_type_d;
  logic [PACKET_LENGTH-1:0]    out_len_q, out_len_d, pkt_len_q, pkt_len_d, dw_cnt_q, dw_cnt_d;
  logic                        proto_err_q, proto_err_d, len_err_q, len_err_d;
  logic [PACKET_LENGTH-1:0]    cur_len, cnt_n;
  logic                        run, wr_en, out_free, ready, acc, drop, wr, held_mv;
  logic                        closing, direct, cur_type, n_sop, in_pkt;

  // State register of the packet-framing FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a packet opens on an accepted SOP without EOP and closes on an accepted EOP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (wr && i_Pkt_SOP && !i_Pkt_EOP) state_d = S_IN_PKT;
      S_IN_PKT: if (wr && i_Pkt_EOP)               state_d = S_IDLE;
      default:                                     state_d = S_IDLE;
    endcase
    if (i_Soft_RST) state_d = S_IDLE;
  end

  // FSM output decode
  always_comb begin
    in_pkt = (state_q == S_IN_PKT);
  end

  // Datapath: handshake, beat assembly, out-stage loading and sticky error flags
  always_comb begin
    run      = i_EN && !i_Soft_RST && !RST;
    wr_en    = out_v_q && !i_Full && run;
    out_free = !out_v_q || wr_en;
    ready    = run && !(fill_cmpl_q && !out_free);
    acc      = i_Pkt_Valid && ready;
    drop     = acc && (in_pkt ? i_Pkt_SOP : !i_Pkt_SOP);
    wr       = acc && !drop;
    held_mv  = run && fill_cmpl_q && out_free;

    // A held complete beat leaves this cycle, so a new DW starts a fresh beat at slot 0
    b_data = fill_cmpl_q ? '0 : fill_data_q;
    b_ptr  = fill_cmpl_q ? '0 : fill_ptr_q;
    n_data = b_data;
    for (int k = 0; k < SLOTS; k++) begin
      if (b_ptr == PTR_W'(k)) n_data[32*k +: 32] = i_Pkt_Data;
    end
    n_sop    = (!fill_cmpl_q && fill_sop_q) || i_Pkt_SOP;
    n_lb     = SYMBOL_PTR_WIDTH'({b_ptr, 2'b11});
    cur_type = i_Pkt_SOP ? i_Pkt_Type   : pkt_type_q;
    cur_len  = i_Pkt_SOP ? i_Pkt_Length : pkt_len_q;
    cnt_n    = i_Pkt_SOP ? PACKET_LENGTH'(1) : dw_cnt_q + 1'b1;
    closing  = wr && (i_Pkt_EOP || b_ptr == PTR_W'(SLOTS - 1));
    direct   = closing && !fill_cmpl_q && out_free;

    fill_data_d = fill_data_q;  fill_ptr_d = fill_ptr_q;   fill_sop_d  = fill_sop_q;
    fill_end_d  = fill_end_q;   fill_lb_d  = fill_lb_q;    fill_cmpl_d = fill_cmpl_q;
    out_v_d     = out_v_q;      out_data_d = out_data_q;   out_sop_d   = out_sop_q;
    out_end_d   = out_end_q;    out_type_d = out_type_q;   out_len_d   = out_len_q;
    out_lb_d    = out_lb_q;     pkt_type_d = pkt_type_q;   pkt_len_d   = pkt_len_q;
    dw_cnt_d    = dw_cnt_q;     proto_err_d = proto_err_q; len_err_d   = len_err_q;

    if (held_mv) begin
      // pkt attributes cannot have changed since this beat completed: Ready was low meanwhile
      out_v_d = 1'b1;  out_data_d = fill_data_q;  out_sop_d = fill_sop_q;  out_end_d = fill_end_q;
      out_lb_d = fill_lb_q;  out_type_d = pkt_type_q;  out_len_d = pkt_len_q;
      fill_data_d = '0;  fill_ptr_d = '0;  fill_sop_d = 1'b0;  fill_end_d = 1'b0;
      fill_lb_d = '0;  fill_cmpl_d = 1'b0;
    end else if (wr_en) begin
      out_v_d = 1'b0;
    end

    if (wr) begin
      dw_cnt_d = cnt_n;
      if (i_Pkt_SOP) begin
        pkt_type_d = i_Pkt_Type;
        pkt_len_d  = i_Pkt_Length;
      end
      if (direct) begin
        // Closing DW bypasses the fill register straight into a free out stage
        out_v_d = 1'b1;  out_data_d = n_data;  out_sop_d = n_sop;  out_end_d = i_Pkt_EOP;
        out_lb_d = n_lb;  out_type_d = cur_type;  out_len_d = cur_len;
        fill_data_d = '0;  fill_ptr_d = '0;  fill_sop_d = 1'b0;  fill_end_d = 1'b0;
        fill_lb_d = '0;  fill_cmpl_d = 1'b0;
      end else begin
        fill_data_d = n_data;  fill_sop_d = n_sop;  fill_end_d = i_Pkt_EOP && closing;
        fill_lb_d = n_lb;  fill_cmpl_d = closing;
        fill_ptr_d = closing ? '0 : b_ptr + 1'b1;
      end
    end

    if (drop || (wr && i_Pkt_SOP && i_Pkt_Length == '0)) proto_err_d = 1'b1;
    if (wr && i_Pkt_EOP && cnt_n != cur_len)             len_err_d   = 1'b1;

    if (i_Soft_RST) begin
      fill_data_d = '0;  fill_ptr_d = '0;  fill_sop_d = 1'b0;  fill_end_d = 1'b0;
      fill_lb_d = '0;  fill_cmpl_d = 1'b0;  out_v_d = 1'b0;  out_data_d = '0;
      out_sop_d = 1'b0;  out_end_d = 1'b0;  out_type_d = 1'b0;  out_len_d = '0;
      out_lb_d = '0;  pkt_type_d = 1'b0;  pkt_len_d = '0;  dw_cnt_d = '0;
      proto_err_d = 1'b0;  len_err_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_data_q <= '0;  fill_ptr_q <= '0;  fill_sop_q <= 1'b0;  fill_end_q <= 1'b0;
      fill_lb_q <= '0;  fill_cmpl_q <= 1'b0;  out_v_q <= 1'b0;  out_data_q <= '0;
      out_sop_q <= 1'b0;  out_end_q <= 1'b0;  out_type_q <= 1'b0;  out_len_q <= '0;
      out_lb_q <= '0;  pkt_type_q <= 1'b0;  pkt_len_q <= '0;  dw_cnt_q <= '0;
      proto_err_q <= 1'b0;  len_err_q <= 1'b0;
    end else begin
      fill_data_q <= fill_data_d;  fill_ptr_q <= fill_ptr_d;  fill_sop_q <= fill_sop_d;
      fill_end_q <= fill_end_d;  fill_lb_q <= fill_lb_d;  fill_cmpl_q <= fill_cmpl_d;
      out_v_q <= out_v_d;  out_data_q <= out_data_d;  out_sop_q <= out_sop_d;
      out_end_q <= out_end_d;  out_type_q <= out_type_d;  out_len_q <= out_len_d;
      out_lb_q <= out_lb_d;  pkt_type_q <= pkt_type_d;  pkt_len_q <= pkt_len_d;
      dw_cnt_q <= dw_cnt_d;  proto_err_q <= proto_err_d;  len_err_q <= len_err_d;
    end
  end

  assign o_Pkt_Ready = ready;
  assign o_WR_EN     = wr_en;
  assign o_SOP       = out_sop_q;
  assign o_End_Valid = out_end_q;
  assign o_Type      = out_type_q;
  assign o_Length    = out_len_q;
  assign o_Last_Byte = out_lb_q;
  assign o_Data      = out_data_q;
  assign o_Proto_Err = proto_err_q;
  assign o_Len_Err   = len_err_q;

endmodule
